// File: rtl/p_bit_seq.sv
// p_bit_seq: sequential stochastic p-bit; accumulates J*m+h over N cycles, scales by beta, samples a spin against an LFSR
module p_bit_seq #(
  parameter int N = 4,
  parameter int JW = 8,
  parameter int HW = 8,
  parameter int BW = 8,
  parameter int BETA_FRAC = 4,
  parameter int LW = 16,
  parameter logic [LW-1:0] SEED = LW'(16'hACE1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [N-1:0]         m_in,
  input  logic [N*JW-1:0]      j_in,
  input  logic signed [HW-1:0] h_in,
  input  logic [BW-1:0]        i_beta,
  output logic                 busy,
  output logic                 valid,
  output logic                 m_out
);
  function automatic logic [31:0] taps(input int w);
    case (w)
      4:       return 32'h0000000C;
      5:       return 32'h00000014;
      6:       return 32'h00000030;
      7:       return 32'h00000060;
      8:       return 32'h000000B8;
      9:       return 32'h00000110;
      10:      return 32'h00000240;
      11:      return 32'h00000500;
      12:      return 32'h00000829;
      13:      return 32'h0000100D;
      14:      return 32'h00002015;
      15:      return 32'h00006000;
      16:      return 32'h0000B400;
      17:      return 32'h00012000;
      18:      return 32'h00020400;
      19:      return 32'h00040023;
      20:      return 32'h00090000;
      21:      return 32'h00140000;
      22:      return 32'h00300000;
      23:      return 32'h00420000;
      24:      return 32'h00E10000;
      25:      return 32'h01200000;
      26:      return 32'h02000023;
      27:      return 32'h04000013;
      28:      return 32'h09000000;
      29:      return 32'h14000000;
      30:      return 32'h20000029;
      31:      return 32'h48000000;
      default: return 32'h80200003;
    endcase
  endfunction
  localparam int MW = JW > HW ? JW : HW;
  localparam int ACCW = MW + $clog2(N + 1) + 1;
  localparam int PW = ACCW + BW + 1;
  localparam int CW = (PW > LW ? PW : LW) + 1;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam logic [LW-1:0] TAPS = LW'(taps(LW));
  localparam logic [LW-1:0] SEED_I = (SEED == '0) ? LW'(1) : SEED;
  localparam logic signed [CW-1:0] HI = (CW'(1) <<< (LW - 1)) - CW'(1);
  localparam logic signed [CW-1:0] LO = -(CW'(1) <<< (LW - 1));
  typedef enum logic [1:0] {IDLE, ACC, SCALE, ACT} state_t;
  state_t                 state_q, state_d;
  logic [N-1:0]           m_q, m_d;
  logic [N*JW-1:0]        j_q, j_d;
  logic [BW-1:0]          beta_q, beta_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [PW-1:0]   x_q, x_d;
  logic [KW-1:0]          k_q, k_d;
  logic [LW-1:0]          lfsr_q, lfsr_d;
  logic                   valid_q, valid_d;
  logic                   m_out_q, m_out_d;
  logic signed [JW-1:0]   j_k;
  logic signed [PW-1:0]   prod;
  logic signed [CW-1:0]   x_c, r_c;
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    j_d = j_q;
    beta_d = beta_q;
    acc_d = acc_q;
    x_d = x_q;
    k_d = k_q;
    valid_d = 1'b0;
    m_out_d = m_out_q;
    lfsr_d = {lfsr_q[LW-2:0], ^(lfsr_q & TAPS)};
    j_k = j_q[k_q*JW +: JW];
    prod = PW'(acc_q) * PW'($signed({1'b0, beta_q}));
    x_c = CW'(x_q);
    r_c = CW'($signed(lfsr_q));
    case (state_q)
      IDLE: if (start) begin
        m_d = m_in;
        j_d = j_in;
        beta_d = i_beta;
        acc_d = ACCW'(h_in);
        k_d = '0;
        state_d = ACC;
      end
      ACC: begin
        acc_d = m_q[k_q] ? acc_q + ACCW'(j_k) : acc_q - ACCW'(j_k);
        k_d = k_q + 1'b1;
        state_d = (k_q == KW'(N - 1)) ? SCALE : ACC;
      end
      SCALE: begin
        x_d = prod >>> BETA_FRAC;
        state_d = ACT;
      end
      default: begin
        m_out_d = x_c >= HI ? 1'b1 : x_c <= LO ? 1'b0 : x_c > r_c;
        valid_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      m_q <= '0;
      j_q <= '0;
      beta_q <= '0;
      acc_q <= '0;
      x_q <= '0;
      k_q <= '0;
      lfsr_q <= SEED_I;
      valid_q <= 1'b0;
      m_out_q <= 1'b1;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      j_q <= j_d;
      beta_q <= beta_d;
      acc_q <= acc_d;
      x_q <= x_d;
      k_q <= k_d;
      lfsr_q <= lfsr_d;
      valid_q <= valid_d;
      m_out_q <= m_out_d;
    end
  end
  assign busy = state_q != IDLE;
  assign valid = valid_q;
  assign m_out = m_out_q;
endmodule
